// File: rtl/noc_input_fifo.sv
// Per-port input buffer of the NoC router: valid/ready push from the link,
// show-ahead head packet with has-packet/read-enable pop toward the arbiter.
package pa_noc;
    localparam int PACKET_WIDTH = 16;
endpackage

module noc_input_fifo #(
    parameter  int DEPTH        = 4,
    localparam int PACKET_WIDTH = pa_noc::PACKET_WIDTH,
    localparam int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    input  logic [PACKET_WIDTH-1:0] i_packet,
    input  logic                    i_packetIsValid,
    output logic                    o_fifoReady,
    output logic                    o_fifoHasPacket,
    output logic [PACKET_WIDTH-1:0] o_fifoReadData,
    input  logic                    i_fifoReadEn,
    output logic [CNT_W-1:0]        o_fifoCount,
    output logic                    o_readErr
);
    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: a push happens at an edge where i_packetIsValid && o_fifoReady;
    // a pop happens at an edge where i_fifoReadEn && o_fifoHasPacket.
    logic [PACKET_WIDTH-1:0] mem_q [DEPTH];
    logic [PACKET_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    read_err_q, read_err_d;
    logic                    push, pop;

    always_comb begin
        push       = i_packetIsValid && (count_q != CNT_W'(DEPTH));
        pop        = i_fifoReadEn && (count_q != '0);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        read_err_d = read_err_q | (i_fifoReadEn && (count_q == '0));

        if (push) begin
            mem_d[wr_ptr_q] = i_packet;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Full blocks push, so push+pop never overflows the count.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            read_err_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            read_err_q <= read_err_d;
        end
    end

    assign o_fifoReady     = (count_q != CNT_W'(DEPTH));
    assign o_fifoHasPacket = (count_q != '0);
    assign o_fifoReadData  = mem_q[rd_ptr_q];
    assign o_fifoCount     = count_q;
    assign o_readErr       = read_err_q;
endmodule

// File: tb/tb_noc_input_fifo.sv
// Directed plus random stimulus for noc_input_fifo, checked against a queue model.
module tb_noc_input_fifo;
    localparam int DEPTH = 4;
    localparam int PW    = pa_noc::PACKET_WIDTH;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          i_clk = 1'b0;
    logic          i_arst_n;
    logic [PW-1:0] i_packet;
    logic          i_packetIsValid;
    logic          o_fifoReady;
    logic          o_fifoHasPacket;
    logic [PW-1:0] o_fifoReadData;
    logic          i_fifoReadEn;
    logic [CW-1:0] o_fifoCount;
    logic          o_readErr;

    logic [PW-1:0] exp_q[$];
    logic          exp_err;
    int            passed = 0;
    int            total  = 0;

    always #5 i_clk = ~i_clk;

    noc_input_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk           (i_clk),
        .i_arst_n        (i_arst_n),
        .i_packet        (i_packet),
        .i_packetIsValid (i_packetIsValid),
        .o_fifoReady     (o_fifoReady),
        .o_fifoHasPacket (o_fifoHasPacket),
        .o_fifoReadData  (o_fifoReadData),
        .i_fifoReadEn    (i_fifoReadEn),
        .o_fifoCount     (o_fifoCount),
        .o_readErr       (o_readErr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(o_fifoReady), 32'd1);
        check({tag, "_has"},   32'(o_fifoHasPacket), 32'd0);
        check({tag, "_count"}, 32'(o_fifoCount), 32'd0);
        check({tag, "_err"},   32'(o_readErr), 32'd0);
        check({tag, "_data"},  32'(o_fifoReadData), 32'd0);
    endtask

    // Compares every output against the model; head data only when non-empty.
    task automatic check_all(input string tag);
        check({tag, "_ready"}, 32'(o_fifoReady), 32'(exp_q.size() != DEPTH));
        check({tag, "_has"},   32'(o_fifoHasPacket), 32'(exp_q.size() != 0));
        check({tag, "_count"}, 32'(o_fifoCount), 32'(exp_q.size()));
        check({tag, "_err"},   32'(o_readErr), 32'(exp_err));
        if (exp_q.size() != 0)
            check({tag, "_data"}, 32'(o_fifoReadData), 32'(exp_q[0]));
    endtask

    // Called at a falling edge: drive, model the rising edge, check at next falling edge.
    task automatic cycle(input string tag, input logic v, input logic [PW-1:0] d, input logic re);
        bit do_push, do_pop;
        i_packetIsValid = v;
        i_packet        = d;
        i_fifoReadEn    = re;
        do_push = v && (exp_q.size() < DEPTH);
        do_pop  = re && (exp_q.size() > 0);
        if (re && exp_q.size() == 0) exp_err = 1'b1;
        @(posedge i_clk);
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(d);
        @(negedge i_clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        i_arst_n = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        repeat (3) @(negedge i_clk);
        i_arst_n = 1'b1;
        @(negedge i_clk);
    endtask

    initial begin
        i_arst_n        = 1'b0;
        i_packet        = '0;
        i_packetIsValid = 1'b0;
        i_fifoReadEn    = 1'b0;
        exp_err         = 1'b0;

        // Reset then idle
        do_reset();
        check_reset_values("reset_idle");

        // Empty pop sets the sticky error
        cycle("empty_pop", 1'b0, '0, 1'b1);
        check("empty_pop_err_const", 32'(o_readErr), 32'd1);

        // Fill and drain
        for (int i = 0; i < 4; i++) cycle("fill", 1'b1, PW'(32'hA1 + i), 1'b0);
        check("full_ready_const", 32'(o_fifoReady), 32'd0);
        check("full_count_const", 32'(o_fifoCount), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain_head_const", 32'(o_fifoReadData), 32'hA1 + 32'(i));
            cycle("drain", 1'b0, '0, 1'b1);
        end
        check("drained_has_const", 32'(o_fifoHasPacket), 32'd0);

        // Full blocking: push while full is ignored even with a pop
        for (int i = 0; i < 4; i++) cycle("refill", 1'b1, PW'(32'hA1 + i), 1'b0);
        cycle("full_block", 1'b1, PW'(16'hB5), 1'b1);
        check("full_block_count", 32'(o_fifoCount), 32'd3);
        cycle("full_retry", 1'b1, PW'(16'hB5), 1'b0);
        for (int i = 0; i < 4; i++) cycle("full_drain", 1'b0, '0, 1'b1);

        // Simultaneous push/pop at count=2 across pointer wraps
        cycle("sim_pre", 1'b1, PW'(16'h11), 1'b0);
        cycle("sim_pre", 1'b1, PW'(16'h22), 1'b0);
        for (int i = 0; i < 10; i++) cycle("sim_pp", 1'b1, PW'(32'hC0 + i), 1'b1);
        check("sim_count_const", 32'(o_fifoCount), 32'd2);
        check("sim_head_const", 32'(o_fifoReadData), 32'hC8);

        // Async reset between edges with count=3
        cycle("pre_ar", 1'b1, PW'(16'h31), 1'b0);
        cycle("pre_ar", 1'b0, '0, 1'b0);
        i_packetIsValid = 1'b0;
        #2 i_arst_n = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge i_clk);
        i_arst_n = 1'b1;
        cycle("post_ar", 1'b1, PW'(16'hD7), 1'b0);
        check("post_ar_head_const", 32'(o_fifoReadData), 32'hD7);

        // Randomised traffic
        for (int i = 0; i < 300; i++)
            cycle("rand", 1'($urandom_range(0, 1)), PW'($urandom), 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/noc_input_fifo.md
Name: noc_input_fifo

Overview:
- Per-port input buffer of the NoC router.
- Link side: accepts packets from a neighbouring router or local node using a valid/ready handshake.
- Arbiter side: presents the head packet with a has-packet flag and pops on a read-enable.
- The router instantiates five of these, one per input direction. Their has-packet, read-data and read-enable signals form the per-FIFO slices the router arbiter consumes.

Parameters:
- PACKET_WIDTH, pa_noc::PACKET_WIDTH (localparam, not overridable): packet width in bits.
- DEPTH, 4: number of packet entries. Must be a power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1 (localparam): occupancy counter width.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_arst_n  input  1  asynchronous active-low reset.
- i_packet  input  PACKET_WIDTH  incoming packet from link.
- i_packetIsValid  input  1  i_packet is valid this cycle.
- o_fifoReady  output  1  FIFO can accept a packet this cycle.
- o_fifoHasPacket  output  1  at least one packet is stored.
- o_fifoReadData  output  PACKET_WIDTH  head packet (show-ahead).
- i_fifoReadEn  input  1  pop head packet at this edge.
- o_fifoCount  output  CNT_W  current occupancy, 0..DEPTH.
- o_readErr  output  1  sticky: pop requested while empty.

Behaviour:
- Reset is asynchronous on i_arst_n low; release is synchronous to i_clk.
- While in reset: write pointer = 0, read pointer = 0, count = 0, all storage entries = 0, o_readErr = 0.
- Outputs in reset: o_fifoReady = 1, o_fifoHasPacket = 0, o_fifoReadData = 0, o_fifoCount = 0.
- Reset mid-operation discards all stored packets immediately, with no clock edge required.
- Storage is a flop array of DEPTH entries. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write (push) fires when i_packetIsValid && o_fifoReady at the edge:
  - i_packet is stored at the write pointer.
  - The write pointer increments.
- Read (pop) fires when i_fifoReadEn && o_fifoHasPacket at the edge:
  - The read pointer increments.
- All outputs are derived from registered state only; no combinational path from any input to any output:
  - o_fifoReady = (count != DEPTH).
  - o_fifoHasPacket = (count != 0).
  - o_fifoReadData = storage[read pointer], valid when o_fifoHasPacket = 1. Value when empty is the stale entry and must not be relied on.
  - o_fifoCount = count.
- Count update per edge:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Latency: a packet written at edge N is visible on o_fifoReadData with o_fifoHasPacket = 1 after edge N. There is no write-through bypass when empty.
- Full:
  - o_fifoReady = 0, so push is blocked even if a pop occurs in the same cycle (no full-bypass).
  - o_fifoReady returns to 1 the cycle after a pop.
  - The link sender must hold i_packet and i_packetIsValid stable until accepted.
- Empty:
  - i_fifoReadEn is ignored: pointers and count are unchanged.
  - o_readErr is set to 1 at that edge and stays 1 until reset.
- Simultaneous push and pop with 0 < count < DEPTH: both occur; the head advances and the new entry is appended.
- Packet order is strictly preserved (FIFO). Packet contents pass through unmodified.
- i_packetIsValid = 0 with o_fifoReady = 1 causes no state change.

Test Plan:
- Reset then idle: hold i_arst_n low 3 cycles, then release → o_fifoReady=1, o_fifoHasPacket=0, o_fifoCount=0, o_readErr=0, o_fifoReadData=0.
- Fill and drain, DEPTH=4: push 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles → count 1,2,3,4; o_fifoReady=0 after the 4th. Then pop 4 cycles → o_fifoReadData shows A1,A2,A3,A4 in order; count ends 0 and o_fifoHasPacket=0.
- Full blocking: with the FIFO full, drive i_packetIsValid=1 with 0xB5 and i_fifoReadEn=1 → pop only, count 3. Next cycle o_fifoReady=1 and 0xB5 is pushed; drain order is A2,A3,A4,B5.
- Simultaneous push/pop with count=2: over 10 cycles, push 0xC0..0xC9 while popping every cycle → count stays 2, output stream is the original 2 entries followed by C0..C7, and pointers wrap at least twice.
- Empty pop: from reset, assert i_fifoReadEn for 1 cycle → count stays 0, o_readErr=1 and holds across later pushes/pops until i_arst_n is asserted.
- Async reset mid-stream: with count=3, pull i_arst_n low between clock edges → outputs return to reset values before the next edge; after release the first push of 0xD7 appears as head.
